// File: rtl/intra_interp_sum.sv
// Two-stage 4-tap sum, VVC rounding (+32 >>> 6) and 8-bit clip with valid/ready
// handshake and an end-of-row marker every BLK_W output samples.
module intra_interp_sum #(
    parameter int BLK_W = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_p0,
    input  logic signed [15:0] in_p1,
    input  logic signed [15:0] in_p2,
    input  logic signed [15:0] in_p3,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_data,
    output logic               out_last,
    output logic               out_clip
);

    logic               s1_valid;
    logic signed [16:0] s01, s23;
    logic [CNT_W-1:0]   pos;
    logic               s2_adv, s1_adv;
    logic signed [18:0] t, r;
    logic [7:0]         clip_data;
    logic               clip_hit;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign out_last = out_valid && (pos == CNT_W'(BLK_W - 1));

    // 19 bits: four full-scale products plus the rounding offset overflow 18.
    always_comb begin
        t         = {{2{s01[16]}}, s01} + {{2{s23[16]}}, s23} + 19'sd32;
        r         = t >>> 6;
        clip_data = r[7:0];
        clip_hit  = 1'b0;
        if (r < 19'sd0) begin
            clip_data = 8'd0;
            clip_hit  = 1'b1;
        end else if (r > 19'sd255) begin
            clip_data = 8'd255;
            clip_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s01       <= '0;
            s23       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_clip  <= 1'b0;
            pos       <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s01 <= {in_p0[15], in_p0} + {in_p1[15], in_p1};
                    s23 <= {in_p2[15], in_p2} + {in_p3[15], in_p3};
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= clip_data;
                    out_clip <= clip_hit;
                end
            end
            if (out_valid && out_ready)
                pos <= out_last ? '0 : pos + 1'b1;
        end
    end

endmodule

// File: tb/tb_intra_interp_sum.sv
// Scoreboard bench for intra_interp_sum: driver pushes model results on input
// transfers, a negedge monitor pops and compares on output transfers.
module tb_intra_interp_sum;

    localparam int BLK_W = 32;
    localparam int CNT_W = 6;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_p0 = '0, in_p1 = '0, in_p2 = '0, in_p3 = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [7:0]         out_data;
    logic               out_last;
    logic               out_clip;

    intra_interp_sum #(.BLK_W(BLK_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_p0(in_p0), .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_clip(out_clip)
    );

    always #5 clk = ~clk;

    typedef struct { int data; bit clip; bit last; } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int in_row = 0;
    int xfer_cnt = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int rdy_mode = 0;  // 0: always 1, 1: 1-0-0-1 pattern, 2: random
    int rdy_cyc = 0;
    bit was_rst = 1'b1;
    bit prev_stall = 1'b0;
    logic [7:0] pd;
    logic pl, pc;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, floor shift, saturate to [0,255].
    function automatic exp_t model(input int a, input int b, input int c, input int d, input bit last);
        exp_t e;
        int r;
        r = (a + b + c + d + 32) >>> 6;
        e.clip = (r < 0) || (r > 255);
        e.data = (r < 0) ? 0 : (r > 255) ? 255 : r;
        e.last = last;
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        rdy_cyc++;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rdy_cyc % 4 == 0) || (rdy_cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            in_row = 0;
            was_rst = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (was_rst) begin
                chk(!out_valid, "rst_out_valid", int'(out_valid), 0);
                chk(out_data == 8'd0, "rst_out_data", int'(out_data), 0);
                chk(!out_last, "rst_out_last", int'(out_last), 0);
                chk(!out_clip, "rst_out_clip", int'(out_clip), 0);
                chk(in_ready, "rst_in_ready", int'(in_ready), 1);
                was_rst = 1'b0;
            end
            chk(in_ready == !(q.size() == 2 && !out_ready), "in_ready",
                int'(in_ready), int'(!(q.size() == 2 && !out_ready)));
            if (q.size() == 0)
                chk(!out_valid, "idle_valid", int'(out_valid), 0);
            if (prev_stall)
                chk(out_valid && out_data == pd && out_last == pl && out_clip == pc,
                    "stall_hold", int'(out_data), int'(pd));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(1'b0, "spurious_out", int'(out_data), -1);
                end else begin
                    e = q.pop_front();
                    chk(int'(out_data) == e.data, "out_data", int'(out_data), e.data);
                    chk(out_clip == e.clip, "out_clip", int'(out_clip), int'(e.clip));
                    chk(out_last == e.last, "out_last", int'(out_last), int'(e.last));
                end
                if (xfer_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfer_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pl = out_last; pc = out_clip;
            if (in_valid && in_ready) begin
                q.push_back(model(int'(in_p0), int'(in_p1), int'(in_p2), int'(in_p3),
                                  in_row == BLK_W - 1));
                in_row = (in_row + 1) % BLK_W;
            end
        end
    end

    task automatic send(input int a, input int b, input int c, input int d);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_p0 = a[15:0]; in_p1 = b[15:0]; in_p2 = c[15:0]; in_p3 = d[15:0];
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk(1'b0, "send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) chk(1'b0, "drain_timeout", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int rnd_p();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 8000)) - 2000;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // rounding and clipping corners
        send(-400, 3600, 2400, -300);
        send(31, 0, 0, 0);
        send(32, 0, 0, 0);
        send(-1000, 0, 0, 0);
        send(32767, 32767, 32767, 32767);
        send(-32768, -32768, -32768, -32768);
        send(16352, 0, 0, 0);
        send(16384, 0, 0, 0);
        drain();

        // 64 back-to-back samples, two full rows
        do_reset();
        xfer_cnt = 0;
        for (int i = 0; i < 64; i++) send(i * 64, i, -i, 7);
        drain();
        chk(xfer_cnt == 64, "stream_count", xfer_cnt, 64);
        chk(last_cyc - first_cyc == 63, "stream_span", last_cyc - first_cyc, 63);

        // backpressure 1-0-0-1
        rdy_mode = 1;
        xfer_cnt = 0;
        for (int i = 0; i < 10; i++) send(i * 640 + 100, 50, -20, i);
        drain();
        chk(xfer_cnt == 10, "bp_count", xfer_cnt, 10);

        // reset with samples in flight, garbage presented during reset
        rdy_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(1000, i, 0, 0);
        chk(out_valid, "pre_rst_valid", int'(out_valid), 1);
        in_valid = 1'b1;
        in_p0 = 16'sd5000;
        do_reset();
        in_valid = 1'b0;
        xfer_cnt = 0;
        for (int i = 0; i < 32; i++) send(i * 500, 0, 0, 0);
        drain();
        chk(xfer_cnt == 32, "post_rst_count", xfer_cnt, 32);

        // random traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(rnd_p(), rnd_p(), rnd_p(), rnd_p());
            if ($urandom_range(0, 4) == 0) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
